// File: rtl/ldo_mode_ctrl_if.sv
// Bundle of comparator/fine-code inputs and step/selection outputs for ldo_mode_ctrl.
//   master : loop environment side (drives en, cmp_hi, fine_code; observes control outputs)
//   slave  : controller side (ldo_mode_ctrl)
// Signals:
//   en        loop enable
//   cmp_hi    asynchronous comparator, 1 = Vout above Vref
//   fine_code fine thermometer code fed back from the downstream shift register
//   step      one-cycle request to shift the selected array by one unit
//   up        step direction, 1 = add one unit (raise Vout)
//   fine_en   fine array selected
//   coarse_en coarse array selected
//   locked    high while the loop is locked
interface ldo_mode_ctrl_if;
  localparam int unsigned FINE_W = 16;

  logic              en;
  logic              cmp_hi;
  logic [FINE_W-1:0] fine_code;
  logic              step;
  logic              up;
  logic              fine_en;
  logic              coarse_en;
  logic              locked;

  modport master (
    output en, cmp_hi, fine_code,
    input  step, up, fine_en, coarse_en, locked
  );

  modport slave (
    input  en, cmp_hi, fine_code,
    output step, up, fine_en, coarse_en, locked
  );
endinterface

// File: rtl/ldo_mode_ctrl.sv
// Digital LDO mode controller: coarse search with settling gaps, fine tracking,
// lock detection on repeated direction reversals and unlock on a sustained
// comparator run.
// Ports:
//   clk  single clock, all state on the rising edge
//   rst  synchronous active-high reset
//   bus  ldo_mode_ctrl_if.slave (en, cmp_hi, fine_code in; step, up, fine_en,
//        coarse_en, locked out, all registered)
module ldo_mode_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned LOCK_TOGGLES = 4,
  parameter int unsigned UNLOCK_RUN   = 4
) (
  input  logic           clk,
  input  logic           rst,
  ldo_mode_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WARM_W = (SYNC_STAGES < 2) ? 1 : $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COARSE = 3'd1,
    SETTLE = 3'd2,
    FINE   = 3'd3,
    LOCK   = 3'd4
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [WARM_W-1:0]      warm_q;
  logic [CNT_W-1:0]       settle_q;
  logic [CNT_W-1:0]       tog_q;
  logic [CNT_W-1:0]       tog_d;
  logic [CNT_W-1:0]       run_q;
  logic [CNT_W-1:0]       run_d;
  logic                   coarse_prev_q;
  logic                   coarse_vld_q;
  logic                   fine_prev_q;
  logic                   fine_vld_q;
  logic                   lock_prev_q;
  logic                   lock_vld_q;
  logic                   step_q;
  logic                   up_q;
  logic                   fine_en_q;
  logic                   coarse_en_q;
  logic                   locked_q;

  logic cmp_s;
  logic want_up;
  logic fine_full;
  logic fine_empty;
  logic fine_sat;

  assign cmp_s      = sync_q[SYNC_STAGES-1];
  assign want_up    = ~cmp_s;
  assign fine_full  = &bus.fine_code;
  assign fine_empty = ~|bus.fine_code;
  // Fine array cannot move further in the requested direction.
  assign fine_sat   = want_up ? fine_full : fine_empty;

  // Saturating reversal / run counters for the fine and lock states.
  always_comb begin
    tog_d = '0;
    if (fine_vld_q && (fine_prev_q != want_up)) begin
      tog_d = (tog_q == '1) ? tog_q : tog_q + CNT_W'(1);
    end
    run_d = CNT_W'(1);
    if (lock_vld_q && (lock_prev_q == cmp_s)) begin
      run_d = (run_q == '1) ? run_q : run_q + CNT_W'(1);
    end
  end

  // Mode FSM with registered outputs; outputs reflect the state that made the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      warm_q        <= '0;
      settle_q      <= '0;
      tog_q         <= '0;
      run_q         <= '0;
      coarse_prev_q <= 1'b0;
      coarse_vld_q  <= 1'b0;
      fine_prev_q   <= 1'b0;
      fine_vld_q    <= 1'b0;
      lock_prev_q   <= 1'b0;
      lock_vld_q    <= 1'b0;
      step_q        <= 1'b0;
      up_q          <= 1'b0;
      fine_en_q     <= 1'b0;
      coarse_en_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      sync_q      <= SYNC_STAGES'({sync_q, bus.cmp_hi});
      step_q      <= 1'b0;
      up_q        <= 1'b0;
      fine_en_q   <= 1'b0;
      coarse_en_q <= 1'b0;
      locked_q    <= 1'b0;

      if (!bus.en) begin
        state_q      <= IDLE;
        warm_q       <= '0;
        settle_q     <= '0;
        tog_q        <= '0;
        run_q        <= '0;
        coarse_vld_q <= 1'b0;
        fine_vld_q   <= 1'b0;
        lock_vld_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= COARSE;
          end

          COARSE: begin
            coarse_en_q <= 1'b1;
            // Wait until the synchronizer holds only samples taken since enable.
            if (warm_q != WARM_W'(SYNC_STAGES)) begin
              warm_q <= warm_q + WARM_W'(1);
            end else begin
              step_q        <= 1'b1;
              up_q          <= want_up;
              coarse_prev_q <= want_up;
              coarse_vld_q  <= 1'b1;
              // A coarse reversal means Vref lies within one coarse unit: hand over to fine.
              if (coarse_vld_q && (coarse_prev_q != want_up)) begin
                state_q    <= FINE;
                tog_q      <= '0;
                fine_vld_q <= 1'b0;
              end else begin
                state_q  <= SETTLE;
                settle_q <= CNT_W'(SETTLE_CYC);
              end
            end
          end

          SETTLE: begin
            coarse_en_q <= 1'b1;
            if (settle_q <= CNT_W'(1)) begin
              settle_q <= '0;
              state_q  <= COARSE;
            end else begin
              settle_q <= settle_q - CNT_W'(1);
            end
          end

          FINE: begin
            fine_en_q <= 1'b1;
            // Saturation wins over lock detection.
            if (fine_sat) begin
              state_q    <= COARSE;
              tog_q      <= '0;
              fine_vld_q <= 1'b0;
            end else begin
              step_q      <= 1'b1;
              up_q        <= want_up;
              fine_prev_q <= want_up;
              fine_vld_q  <= 1'b1;
              if (tog_d >= CNT_W'(LOCK_TOGGLES)) begin
                state_q    <= LOCK;
                tog_q      <= '0;
                run_q      <= '0;
                lock_vld_q <= 1'b0;
              end else begin
                tog_q <= tog_d;
              end
            end
          end

          LOCK: begin
            fine_en_q   <= 1'b1;
            locked_q    <= 1'b1;
            lock_prev_q <= cmp_s;
            lock_vld_q  <= 1'b1;
            if (run_d >= CNT_W'(UNLOCK_RUN)) begin
              state_q    <= FINE;
              run_q      <= '0;
              tog_q      <= '0;
              fine_vld_q <= 1'b0;
            end else begin
              run_q <= run_d;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.step      = step_q;
  assign bus.up        = up_q;
  assign bus.fine_en   = fine_en_q;
  assign bus.coarse_en = coarse_en_q;
  assign bus.locked    = locked_q;

endmodule
